planificador_mantenimiento: RTL and testbench
=============================================

// Module: planificador_mantenimiento
// PURPOSE
//  Upstream scheduler for mantenimiento_fsm: accumulates usage ticks, requests maintenance at a threshold
//  or on manual demand, and drives the FSM's iniciar/detener. Watches terminado with a timeout watchdog and
//  aborts hung runs. Exposes usage, completed-run and fault counters for status/debug.
// PARAMETERS
//  CNT_W              16    width of contador_uso
//  UMBRAL             1000  usage ticks that make maintenance due (1..2**CNT_W-1)
//  TIMEOUT            64    max cycles in EN_CURSO waiting for terminado (>=2)
//  RETARDO_REINTENTO  4     cycles waited in REINTENTO before relaunch (only with PLAN_REINTENTO_EN)
// PORTS
//  clk               in   1      clock, all logic on rising edge
//  reset             in   1      synchronous, active-high reset
//  tick_uso          in   1      one-cycle usage tick
//  solicitud_manual  in   1      manual maintenance request (level sampled in REPOSO only)
//  cancelar          in   1      abort running maintenance / clear pending usage
//  terminado         in   1      completion from mantenimiento_fsm
//  iniciar           out  1      start pulse to mantenimiento_fsm
//  detener           out  1      stop pulse to mantenimiento_fsm
//  pendiente         out  1      contador_uso == UMBRAL
//  ocupado           out  1      state != REPOSO
//  estado_plan       out  3      current state encoding (estado_plan_t)
//  contador_uso      out  CNT_W  accumulated usage ticks
//  completados       out  8      successful runs, saturating at 255
//  fallos            out  8      timeouts, saturating at 255
// BEHAVIOUR
//  - Reset: state REPOSO; iniciar=detener=pendiente=ocupado=0; contador_uso=completados=fallos=0; timers 0.
//  - All outputs registered or pure decode of state/counter registers; no input-to-output combinational path.
//  - contador_uso: +1 on tick_uso in REPOSO/REINTENTO, saturates at UMBRAL; ticks in LANZAR/EN_CURSO/ABORTAR dropped.
//  - States: REPOSO, LANZAR, EN_CURSO, ABORTAR, REINTENTO.
//  - REPOSO: cancelar -> clear contador_uso, stay (cancelar beats requests); else pendiente|solicitud_manual -> LANZAR.
//  - LANZAR: iniciar=1 exactly this one cycle; clear watchdog; -> EN_CURSO. Request at edge k => iniciar in cycle k+1.
//  - EN_CURSO: watchdog +1 per cycle. Priority: terminado -> REPOSO, contador_uso=0, completados+1;
//    else cancelar -> ABORTAR (no fault); else watchdog==TIMEOUT-1 -> ABORTAR, fallos+1 (timeout flag set).
//  - terminado and cancelar same cycle: completion wins. terminado outside EN_CURSO ignored.
//  - ABORTAR: detener=1 exactly one cycle; -> REPOSO (or REINTENTO, see CONFIGURATION).
//  - After abort contador_uso kept: pendiente still high relaunches on next REPOSO cycle unless cancelar.
//  - solicitud_manual while ocupado ignored (not latched). Counters never wrap.
//  - Reset mid-operation: next cycle all reset values; no detener is issued.
// CONFIGURATION
//  PLAN_REINTENTO_EN defined: ABORTAR caused by timeout with retry flag clear -> REINTENTO, set retry flag;
//    REINTENTO waits RETARDO_REINTENTO cycles then -> LANZAR; cancelar in REINTENTO -> REPOSO.
//    Second timeout -> REPOSO. Retry flag cleared on entering REPOSO. Each timeout still counts in fallos.
//  Not defined: REINTENTO unreachable, ABORTAR always -> REPOSO; RETARDO_REINTENTO unused.
// STRUCTURE
//  plan_mant_pkg: typedef enum logic [2:0] estado_plan_t {REPOSO,LANZAR,EN_CURSO,ABORTAR,REINTENTO};
//    localparam widths for status counters (8), saturation max constant.
//  Sub-module contador_sat (param W, inc, clr, sat value) instanced for completados and fallos.
//  Watchdog width $clog2(TIMEOUT+1) as localparam in this module.
// TESTING (UMBRAL=4, TIMEOUT=8, RETARDO_REINTENTO=4)
//  1 reset held 3 cycles with toggling inputs -> all outputs 0, estado_plan=REPOSO.
//  2 4 tick_uso -> pendiente=1, iniciar one cycle next; terminado 3 cycles later -> contador_uso=0, completados=1, ocupado=0.
//  3 solicitud_manual at contador_uso=1, no terminado -> iniciar, 8 cycles EN_CURSO, detener one cycle, fallos=1, contador_uso=1.
//  4 cancelar in EN_CURSO -> detener, fallos=0; repeat with terminado+cancelar same cycle -> completados+1, no detener.
//  5 reset asserted in EN_CURSO -> next cycle REPOSO, counters 0, detener never high.
//  6 PLAN_REINTENTO_EN, no terminado -> detener, 4 cycles REINTENTO, second iniciar; second timeout -> REPOSO, fallos=2.

Source files
------------

// File: rtl/plan_mant_pkg.sv
// Shared types and constants for the maintenance scheduler.
package plan_mant_pkg;

  typedef enum logic [2:0] {
    REPOSO    = 3'd0,
    LANZAR    = 3'd1,
    EN_CURSO  = 3'd2,
    ABORTAR   = 3'd3,
    REINTENTO = 3'd4
  } estado_plan_t;

  localparam int                STAT_W   = 8;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

endpackage

// File: rtl/planificador_mantenimiento_if.sv
// Scheduler <-> environment bundle: usage/request inputs, FSM handshake and status outputs.
interface planificador_mantenimiento_if
  import plan_mant_pkg::*;
#(
  parameter int CNT_W = 16
) ();
  logic              tick_uso;
  logic              solicitud_manual;
  logic              cancelar;
  logic              terminado;
  logic              iniciar;
  logic              detener;
  logic              pendiente;
  logic              ocupado;
  estado_plan_t      estado_plan;
  logic [CNT_W-1:0]  contador_uso;
  logic [STAT_W-1:0] completados;
  logic [STAT_W-1:0] fallos;

  modport slave (
    input  tick_uso, solicitud_manual, cancelar, terminado,
    output iniciar, detener, pendiente, ocupado, estado_plan,
           contador_uso, completados, fallos
  );

  modport master (
    output tick_uso, solicitud_manual, cancelar, terminado,
    input  iniciar, detener, pendiente, ocupado, estado_plan,
           contador_uso, completados, fallos
  );
endinterface

// File: rtl/planificador_mantenimiento_contador_sat.sv
// Saturating up-counter with synchronous clear; holds at SAT instead of wrapping.
module contador_sat #(
  parameter int             W   = 8,
  parameter logic [W-1:0]   SAT = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (inc_i && q_q != SAT) q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/planificador_mantenimiento.sv
// Maintenance scheduler: usage threshold / manual launch, timeout watchdog, status counters.
// Optional single automatic retry after a timeout when PLAN_REINTENTO_EN is defined.
module planificador_mantenimiento
  import plan_mant_pkg::*;
#(
  parameter int CNT_W             = 16,
  parameter int UMBRAL            = 1000,
  parameter int TIMEOUT           = 64,
  parameter int RETARDO_REINTENTO = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  planificador_mantenimiento_if.slave  bus
);
  localparam int               WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] UMB     = CNT_W'(UMBRAL);

  estado_plan_t     estado_q, estado_d;
  logic [CNT_W-1:0] contador_q, contador_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             pend_w, fin_ok, cancel_run, timeout;

`ifdef PLAN_REINTENTO_EN
  localparam int              RET_W    = $clog2(RETARDO_REINTENTO + 1);
  localparam logic [RET_W-1:0] RET_LAST = RET_W'(RETARDO_REINTENTO - 1);
  logic             to_q, to_d;     // last abort came from the watchdog
  logic             reint_q, reint_d;
  logic [RET_W-1:0] ret_q, ret_d;
`else
  logic [31:0] unused_retardo;
  assign unused_retardo = 32'(RETARDO_REINTENTO);
`endif

  assign pend_w     = (contador_q == UMB);
  assign fin_ok     = (estado_q == EN_CURSO) && bus.terminado;
  assign cancel_run = (estado_q == EN_CURSO) && !bus.terminado && bus.cancelar;
  assign timeout    = (estado_q == EN_CURSO) && !bus.terminado && !bus.cancelar
                      && (wd_q == WD_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) estado_q <= REPOSO;
    else       estado_q <= estado_d;
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      REPOSO:    if (!bus.cancelar && (pend_w || bus.solicitud_manual)) estado_d = LANZAR;
      LANZAR:    estado_d = EN_CURSO;
      EN_CURSO: begin
        if (fin_ok)                    estado_d = REPOSO;
        else if (cancel_run || timeout) estado_d = ABORTAR;
      end
`ifdef PLAN_REINTENTO_EN
      ABORTAR:   estado_d = (to_q && !reint_q) ? REINTENTO : REPOSO;
      REINTENTO: begin
        if (bus.cancelar)          estado_d = REPOSO;
        else if (ret_q == RET_LAST) estado_d = LANZAR;
      end
`else
      ABORTAR:   estado_d = REPOSO;
      REINTENTO: estado_d = REPOSO;
`endif
      default:   estado_d = REPOSO;
    endcase
  end

  // Outputs are pure decode of registered state/counters
  always_comb begin
    bus.iniciar     = (estado_q == LANZAR);
    bus.detener     = (estado_q == ABORTAR);
    bus.ocupado     = (estado_q != REPOSO);
    bus.estado_plan = estado_q;
    bus.pendiente   = pend_w;
    bus.contador_uso = contador_q;
  end

  // Datapath: usage counter, watchdog, retry bookkeeping
  always_comb begin
    contador_d = contador_q;
    if (estado_q == REPOSO && bus.cancelar)
      contador_d = '0;
    else if ((estado_q == REPOSO || estado_q == REINTENTO) && bus.tick_uso && !pend_w)
      contador_d = contador_q + 1'b1;
    else if (fin_ok)
      contador_d = '0;

    wd_d = wd_q;
    if (estado_q == LANZAR)                         wd_d = '0;
    else if (estado_q == EN_CURSO && wd_q != WD_LAST) wd_d = wd_q + 1'b1;

`ifdef PLAN_REINTENTO_EN
    to_d = to_q;
    if (estado_q == LANZAR)            to_d = 1'b0;
    else if (timeout)                  to_d = 1'b1;

    reint_d = reint_q;
    if (estado_q == REPOSO)                              reint_d = 1'b0;
    else if (estado_q == ABORTAR && to_q && !reint_q)    reint_d = 1'b1;

    ret_d = ret_q;
    if (estado_q == ABORTAR)        ret_d = '0;
    else if (estado_q == REINTENTO) ret_d = ret_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      contador_q <= '0;
      wd_q       <= '0;
`ifdef PLAN_REINTENTO_EN
      to_q       <= 1'b0;
      reint_q    <= 1'b0;
      ret_q      <= '0;
`endif
    end else begin
      contador_q <= contador_d;
      wd_q       <= wd_d;
`ifdef PLAN_REINTENTO_EN
      to_q       <= to_d;
      reint_q    <= reint_d;
      ret_q      <= ret_d;
`endif
    end
  end

  contador_sat #(.W(STAT_W), .SAT(STAT_MAX)) u_completados (
    .clk   (clk),
    .clr_i (reset),
    .inc_i (fin_ok),
    .q_o   (bus.completados)
  );

  contador_sat #(.W(STAT_W), .SAT(STAT_MAX)) u_fallos (
    .clk   (clk),
    .clr_i (reset),
    .inc_i (timeout),
    .q_o   (bus.fallos)
  );
endmodule

// File: tb/tb_planificador_mantenimiento.sv
// Bench for planificador_mantenimiento: vector table, corner sequences, random run vs. reference model.
module tb_planificador_mantenimiento;
  import plan_mant_pkg::*;

  localparam int U = 4;
  localparam int T = 8;
  localparam int R = 4;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  planificador_mantenimiento_if #(.CNT_W(16)) bus ();

  planificador_mantenimiento #(
    .CNT_W(16), .UMBRAL(U), .TIMEOUT(T), .RETARDO_REINTENTO(R)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic t, s, c, d;
    logic ini, det, pend, ocup;
    int   est, uso, comp, fal;
  } vec_t;

  function automatic logic [63:0] pack(input logic ini, det, pend, ocup,
                                       input int est, uso, comp, fal);
    return {25'd0, ini, det, pend, ocup, est[2:0], uso[15:0], comp[7:0], fal[7:0]};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {25'd0, bus.iniciar, bus.detener, bus.pendiente, bus.ocupado,
            3'(bus.estado_plan), bus.contador_uso, bus.completados, bus.fallos};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic t, s, c, d);
    bus.tick_uso = t; bus.solicitud_manual = s; bus.cancelar = c; bus.terminado = d;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; drive(0, 0, 0, 0); step(); reset = 1'b0;
  endtask

  // Reference model: run age / pending flags, not a state encoding
  int m_uso, m_comp, m_fal, m_run, m_ret;
  bit m_launch, m_abort, m_to, m_retried;

  function automatic void m_reset();
    m_uso = 0; m_comp = 0; m_fal = 0; m_run = -1; m_ret = -1;
    m_launch = 0; m_abort = 0; m_to = 0; m_retried = 0;
  endfunction

  function automatic void m_step(input bit t, s, c, d);
    if (!m_launch && m_run < 0 && !m_abort && m_ret < 0) begin
      m_retried = 0;
      if (c) m_uso = 0;
      else begin
        if (s || m_uso == U) m_launch = 1;
        if (t && m_uso < U) m_uso++;
      end
    end else if (m_launch) begin
      m_launch = 0; m_run = 0; m_to = 0;
    end else if (m_run >= 0) begin
      if (d) begin
        m_uso = 0; m_run = -1;
        if (m_comp < 255) m_comp++;
      end else if (c) begin
        m_run = -1; m_abort = 1;
      end else if (m_run == T - 1) begin
        m_run = -1; m_abort = 1; m_to = 1;
        if (m_fal < 255) m_fal++;
      end else m_run++;
    end else if (m_abort) begin
      m_abort = 0;
`ifdef PLAN_REINTENTO_EN
      if (m_to && !m_retried) begin m_retried = 1; m_ret = 0; end
`endif
    end else begin
      if (t && m_uso < U) m_uso++;
      if (c) m_ret = -1;
      else if (m_ret == R - 1) begin m_ret = -1; m_launch = 1; end
      else m_ret++;
    end
  endfunction

  function automatic logic [63:0] m_vec();
    int est;
    est = m_launch ? 1 : (m_run >= 0) ? 2 : m_abort ? 3 : (m_ret >= 0) ? 4 : 0;
    return pack(m_launch, m_abort, m_uso == U, est != 0, est, m_uso, m_comp, m_fal);
  endfunction

  vec_t vt[21];

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    @(negedge clk);

    // Reset held with toggling inputs
    for (int i = 0; i < 3; i++) begin
      drive(i[0], ~i[0], i[0], ~i[0]);
      step();
      chk("reset_state", dut_vec(), 64'd0);
    end
    reset = 1'b0; drive(0, 0, 0, 0);

    //        t s c d  ini det pend ocup est uso comp fal
    vt[0]  = '{1,0,0,0, 0,0,0,0, 0,1,0,0};
    vt[1]  = '{1,0,0,0, 0,0,0,0, 0,2,0,0};
    vt[2]  = '{1,0,0,0, 0,0,0,0, 0,3,0,0};
    vt[3]  = '{1,0,0,0, 0,0,1,0, 0,4,0,0};
    vt[4]  = '{1,0,0,0, 1,0,1,1, 1,4,0,0};
    vt[5]  = '{1,0,0,0, 0,0,1,1, 2,4,0,0};
    vt[6]  = '{1,0,0,0, 0,0,1,1, 2,4,0,0};
    vt[7]  = '{0,0,0,1, 0,0,0,0, 0,0,1,0};
    vt[8]  = '{0,1,0,0, 1,0,0,1, 1,0,1,0};
    vt[9]  = '{0,0,0,0, 0,0,0,1, 2,0,1,0};
    vt[10] = '{0,0,1,0, 0,1,0,1, 3,0,1,0};
    vt[11] = '{0,0,0,0, 0,0,0,0, 0,0,1,0};
    vt[12] = '{0,1,0,0, 1,0,0,1, 1,0,1,0};
    vt[13] = '{0,0,0,0, 0,0,0,1, 2,0,1,0};
    vt[14] = '{0,0,1,1, 0,0,0,0, 0,0,2,0};
    vt[15] = '{0,0,0,0, 0,0,0,0, 0,0,2,0};
    vt[16] = '{1,0,0,0, 0,0,0,0, 0,1,2,0};
    vt[17] = '{1,0,1,0, 0,0,0,0, 0,0,2,0};
    vt[18] = '{0,1,1,0, 0,0,0,0, 0,0,2,0};
    vt[19] = '{0,0,0,1, 0,0,0,0, 0,0,2,0};
    vt[20] = '{1,0,0,0, 0,0,0,0, 0,1,2,0};
    foreach (vt[i]) begin
      drive(vt[i].t, vt[i].s, vt[i].c, vt[i].d);
      step();
      chk($sformatf("vec%0d", i), dut_vec(),
          pack(vt[i].ini, vt[i].det, vt[i].pend, vt[i].ocup,
               vt[i].est, vt[i].uso, vt[i].comp, vt[i].fal));
    end

    // Timeout: manual launch at contador_uso=1, never terminado
    begin
      int en, det, rein, ini;
      en = 0; det = 0; rein = 0; ini = 0;
      do_reset();
      drive(1, 0, 0, 0); step();
      drive(0, 1, 0, 0); step();
      chk("to_iniciar", bus.iniciar, 1);
      drive(0, 0, 0, 0);
      for (int i = 0; i < 40 && bus.estado_plan != REPOSO; i++) begin
        step();
        en   += (bus.estado_plan == EN_CURSO);
        det  += bus.detener;
        rein += (bus.estado_plan == REINTENTO);
        ini  += bus.iniciar;
      end
      chk("to_back_reposo", bus.estado_plan, REPOSO);
      chk("to_uso_kept", bus.contador_uso, 1);
`ifdef PLAN_REINTENTO_EN
      chk("rt_en_cycles", en, 2 * T);
      chk("rt_detener", det, 2);
      chk("rt_wait", rein, R);
      chk("rt_relaunch", ini, 1);
      chk("rt_fallos", bus.fallos, 2);
`else
      chk("to_en_cycles", en, T);
      chk("to_detener", det, 1);
      chk("to_no_relaunch", ini, 0);
      chk("to_fallos", bus.fallos, 1);
`endif
      step();
      chk("to_idle_stays", bus.ocupado, 0);
    end

    // Reset in EN_CURSO
    begin
      int det;
      det = 0;
      do_reset();
      drive(0, 1, 0, 0); step();
      drive(0, 0, 0, 0); step(); step();
      chk("rst_in_run", bus.estado_plan, EN_CURSO);
      reset = 1'b1; step(); reset = 1'b0;
      chk("rst_mid_vec", dut_vec(), 64'd0);
      for (int i = 0; i < 10; i++) begin step(); det += bus.detener; end
      chk("rst_no_detener", det, 0);
    end

    // Random run against the model
    do_reset();
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      bit t, s, c, d, r;
      t = ($urandom_range(99) < 40);
      s = ($urandom_range(99) < 8);
      c = ($urandom_range(99) < 4);
      d = ($urandom_range(99) < 10);
      r = ($urandom_range(999) < 5);
      drive(t, s, c, d);
      reset = r;
      if (r) m_reset(); else m_step(t, s, c, d);
      step();
      chk($sformatf("rand%0d", i), dut_vec(), m_vec());
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
